// File: rtl/arf_drain_fifo_pkg.sv
// Shared definitions for arf drain/source stages: default word width, req margin, clog2 helper.
package arf_drain_fifo_pkg;

    localparam int ARF_DATA_WIDTH = 32;

    // Slots kept free when req drops, covering the one ack the arf operator may still issue.
    localparam int ARF_REQ_MARGIN = 1;

    function automatic int arf_clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/arf_drain_fifo_mem.sv
// Register array for the drain FIFO: one synchronous write port, one asynchronous read port.
module arf_fifo_mem
    import arf_drain_fifo_pkg::*;
#(
    parameter int data_width = ARF_DATA_WIDTH,
    parameter int depth = 4,
    localparam int addr_width = arf_clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/arf_drain_fifo.sv
// Requester-side drain of an arf output port: captures acked words into a FIFO and
// re-presents them as a first-word fall-through valid/ready stream.
//
// state     | meaning (implicit in level, no state register)
// EMPTY     | level == 0, out_valid low
// PARTIAL   | 0 < level < depth-1, in_req high
// NEAR_FULL | level == depth-1, in_req low, one late ack still fits
// FULL      | level == depth, ack without pop is dropped and flags overflow
module arf_drain_fifo
    import arf_drain_fifo_pkg::*;
#(
    parameter int data_width = ARF_DATA_WIDTH,
    parameter int depth = 4,
    localparam int addr_width = arf_clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  in_req,
    input  logic                  in_ack,
    input  logic [data_width-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data,
    output logic [addr_width:0]   level,
    output logic [31:0]           count,
    output logic                  overflow
);

    localparam int lw = addr_width + 1;
    localparam logic [lw-1:0] level_full = lw'(depth);
    localparam logic [lw-1:0] req_limit = lw'(depth - 1 - ARF_REQ_MARGIN);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  accept;
    logic [lw-1:0]         level_next;

    assign out_valid = (level != '0);

    always_comb begin
        push = in_ack;
        pop = out_valid & out_ready;
        full = (level == level_full);
        // A pop in the same cycle frees the slot, so a push at full is still legal then.
        accept = push & (~full | pop);
        level_next = level + lw'(accept) - lw'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            count <= '0;
            overflow <= 1'b0;
            in_req <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + addr_width'(1);
                count <= count + 32'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + addr_width'(1);
            end
            if (push & full & ~pop) begin
                overflow <= 1'b1;
            end
            level <= level_next;
            in_req <= (level_next <= req_limit);
        end
    end

    arf_fifo_mem #(
        .data_width(data_width),
        .depth(depth)
    ) u_mem (
        .clk(clk),
        .we(accept & ~rst),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(out_data)
    );

endmodule

// File: tb/tb_arf_drain_fifo.sv
// Directed bench for arf_drain_fifo (depth 4): vector table plus stream/reset sequences.
module tb_arf_drain_fifo;

    logic        clk;
    logic        rst;
    logic        in_req;
    logic        in_ack;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  level;
    logic [31:0] count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    arf_drain_fifo #(.data_width(32), .depth(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_req(in_req),
        .in_ack(in_ack),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .level(level),
        .count(count),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] d;
        logic        rdy;
        logic        req;
        logic        vld;
        logic [31:0] dat;
        logic [2:0]  lvl;
        logic [31:0] cnt;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic rdy, logic req,
                                logic vld, logic [31:0] dat, logic [2:0] lvl,
                                logic [31:0] cnt, logic ovf);
        vec_t v;
        v.rst = r; v.ack = a; v.d = d; v.rdy = rdy; v.req = req;
        v.vld = vld; v.dat = dat; v.lvl = lvl; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int lvl_m;
        int head;
        int sent;
        int budget;

        rst = 1'b1; in_ack = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        // ack during reset must be ignored
        in_ack = 1'b1; in_data = 32'd77;
        tick();
        in_ack = 1'b0;
        chk("rst_req", 32'(in_req), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", 32'(overflow), 0);

        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_req", 32'(in_req), 1);
            chk("idle_level", 32'(level), 0);
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_count", count, 0);
        end

        //            rst ack  d  rdy req vld dat lvl cnt ovf
        vecs.push_back(mk(0, 1,  0, 1, 1, 1,  0, 1, 1, 0));
        vecs.push_back(mk(0, 1,  1, 1, 1, 1,  1, 1, 2, 0));
        vecs.push_back(mk(0, 1,  2, 1, 1, 1,  2, 1, 3, 0));
        vecs.push_back(mk(0, 1,  3, 1, 1, 1,  3, 1, 4, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0,  0, 0, 4, 0));
        vecs.push_back(mk(0, 1, 10, 0, 1, 1, 10, 1, 5, 0));
        vecs.push_back(mk(0, 1, 11, 0, 1, 1, 10, 2, 6, 0));
        vecs.push_back(mk(0, 1, 12, 0, 0, 1, 10, 3, 7, 0));
        vecs.push_back(mk(0, 1, 13, 0, 0, 1, 10, 4, 8, 0));
        vecs.push_back(mk(0, 1, 99, 0, 0, 1, 10, 4, 8, 1));
        vecs.push_back(mk(0, 0,  0, 0, 0, 1, 10, 4, 8, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 11, 3, 8, 1));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1, 12, 2, 8, 1));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1, 13, 1, 8, 1));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0,  0, 0, 8, 1));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0,  0, 0, 1, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 20, 0, 1, 1, 20, 1, 1, 0));
        vecs.push_back(mk(0, 1, 21, 0, 1, 1, 20, 2, 2, 0));
        vecs.push_back(mk(0, 1, 22, 0, 0, 1, 20, 3, 3, 0));
        vecs.push_back(mk(0, 1, 23, 0, 0, 1, 20, 4, 4, 0));
        vecs.push_back(mk(0, 1, 50, 1, 0, 1, 21, 4, 5, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 22, 3, 5, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1, 23, 2, 5, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 1, 50, 1, 5, 0));
        vecs.push_back(mk(0, 0,  0, 1, 1, 0,  0, 0, 5, 0));

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_ack = vecs[i].ack;
            in_data = vecs[i].d; out_ready = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_req", i), 32'(in_req), 32'(vecs[i].req));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].vld));
            if (vecs[i].vld) chk($sformatf("v%0d_data", i), out_data, vecs[i].dat);
            chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
            chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
        end
        rst = 1'b0; in_ack = 1'b0; out_ready = 1'b0;

        // Stream 0..9 through the 4-deep FIFO with a stalling consumer to wrap the pointers.
        lvl_m = 0; head = 0; sent = 0;
        for (int i = 0; i < 10; i++) begin
            in_ack = 1'b1; in_data = 32'(i);
            out_ready = (i % 3 != 0);
            if (out_ready && lvl_m > 0) begin
                chk("stream_data", out_data, 32'(head));
                head++; lvl_m--;
            end
            lvl_m++; sent++;
            tick();
            chk("stream_level", 32'(level), 32'(lvl_m));
            chk("stream_valid", 32'(out_valid), 32'(lvl_m > 0));
        end
        in_ack = 1'b0;
        chk("stream_count", count, 32'(5 + sent));
        chk("stream_ovf", 32'(overflow), 0);

        budget = 8;
        while (lvl_m > 2 && budget > 0) begin
            out_ready = 1'b1;
            chk("drain_data", out_data, 32'(head));
            head++; lvl_m--;
            tick();
            chk("drain_level", 32'(level), 32'(lvl_m));
            budget--;
        end
        out_ready = 1'b0;
        if (budget == 0) chk("drain_timeout", 32'(lvl_m), 2);

        // Reset with two words buffered; the ack in the same cycle must not be captured.
        rst = 1'b1; in_ack = 1'b1; in_data = 32'd123;
        tick();
        rst = 1'b0; in_ack = 1'b0;
        chk("midrst_level", 32'(level), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_count", count, 0);
        chk("midrst_req", 32'(in_req), 0);
        tick();
        chk("postrst_req", 32'(in_req), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arf_drain_fifo.md
Name: arf_drain_fifo

Overview:
Downstream drain stage for the arf dataflow output port (dout_req_N / dout_ack_N / dout_N). It acts as the requester on the arf req/ack protocol: it holds req high, captures a word on every ack pulse into a circular FIFO, and re-presents the words as a valid/ready stream to the bench consumer or the next fabric. It decouples arf output timing from downstream stalls and provides occupancy, item-count and overflow status for throughput measurement.

Parameters:
data_width, 32, width of each data word.
depth, 4, FIFO entries; power of two, minimum 2.
addr_width, $clog2(depth), pointer width; derived, never overridden.

Ports:
clk  in  1  clock, all logic on posedge.
rst  in  1  reset: synchronous, active-high.
in_req  out  1  request to arf out operator (drives its req_r).
in_ack  in  1  ack pulse from arf; one word per cycle in which it is high.
in_data  in  data_width  arf dout; valid only in cycles where in_ack=1.
out_valid  out  1  FIFO non-empty.
out_ready  in  1  downstream accepts the word this cycle.
out_data  out  data_width  head-of-FIFO word (first-word fall-through).
level  out  addr_width+1  current occupancy, 0..depth.
count  out  32  total words accepted from arf since reset.
overflow  out  1  sticky error flag.

Behaviour:
- Reset (rst=1 at posedge): rd_ptr=wr_ptr=0, level=0, in_req=0, count=0, overflow=0. Hence out_valid=0; out_data=don't-care. rst mid-operation discards all buffered words; in_ack is ignored in the reset cycle.
- push = in_ack. pop = out_valid & out_ready.
- Push: mem[wr_ptr] <= in_data, wr_ptr+1 (wraps modulo depth), count+1 (wraps at 2^32).
- Pop: rd_ptr+1 (wraps). out_data = mem[rd_ptr], combinational from registered state.
- level_next = level + push - pop. Push and pop in the same cycle leave level unchanged and are legal at any level, including full.
- Push while level==depth and no pop: word dropped, pointers/level/count unchanged, overflow <= 1 (cleared only by rst).
- Pop while empty is impossible, because pop requires out_valid.
- in_req is registered: in_req <= (level_next <= depth-2). The one-slot margin absorbs the single ack the arf operator may still issue after in_req falls, because the operator registers ack from the previous cycle's req. With a compliant upstream, overflow never sets.
- in_req stays high while space remains. Consecutive-cycle acks are accepted back to back. No per-word req toggling is required.
- Latency: ack at posedge t → out_valid=1 and out_data=word after posedge t, i.e. visible in cycle t+1. Minimum in-to-out latency is 1 cycle.
- First cycle after reset release: in_req rises at the first non-reset posedge.
- State machine: implicit in level. EMPTY (level=0), PARTIAL, NEAR_FULL (level=depth-1, in_req=0), FULL (level=depth). No separate FSM register.

Decomposition:
- Shared package: default data_width, the clog2 helper, and a localparam for the req margin (1 slot), reused by future drain/source stages.
- One sub-module, arf_fifo_mem: depth×data_width register array with write port (we, waddr, wdata) and async read port (raddr, rdata).
- Pointer, level and handshake logic stay in arf_drain_fifo.

Test Plan:
- Reset then idle, out_ready=1, no acks → in_req=1 from the first post-reset cycle; level=0, out_valid=0, count=0 for 20 cycles.
- Acks with in_data=0,1,2,3 on four consecutive cycles, out_ready=1 → out_data sequence 0,1,2,3, each one cycle after its ack; level never exceeds 1; count=4.
- out_ready=0, acks with data 10,11,12 → level=3 and in_req=0 after the third; one late ack with 13 → level=4, overflow=0; then out_ready=1 → 10,11,12,13 in order; in_req re-asserts once level ≤2.
- Full FIFO (depth=4), out_ready=0, force an extra ack with 99 → overflow=1 and stays 1; level=4; 99 never appears on out_data; count unchanged.
- Full FIFO with simultaneous ack (data 50) and out_ready=1 → level stays 4; head pops; 50 emerges after the 3 older words; overflow=0.
- Stream 10 words through depth=4 to exercise pointer wrap → output order 0..9 preserved; rst asserted mid-stream with level=2 → next cycle level=0, out_valid=0, count=0.
